chip8_draw_seq: RTL and testbench
=================================

# chip8_draw_seq

Sequences the CHIP-8 DXYN sprite draw between the CPU, instruction memory and the display unit. Given a start pulse with X, Y, N and the I register, it fetches N sprite bytes from memory starting at I and issues one draw pulse per row to the display unit. It ORs the per-row collision flags and returns the VF result with a one-cycle done pulse. It frees the CPU from per-row draw bookkeeping and arbitrates its memory reads through a request/grant handshake.

## Interface
- CLIP, default 1: 1 = rows with y+row ≥ 32 are skipped (not fetched, not drawn); 0 = row Y wraps modulo 32.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to execute DXYN; sampled only in IDLE
- x_in  in  6  sprite X (Vx mod 64)
- y_in  in  5  sprite Y (Vy mod 32)
- n_in  in  4  sprite height in rows, 0..15
- i_addr  in  12  sprite base address (I register)
- busy  out  1  high from cycle after accepted start through the DONE cycle
- done  out  1  one-cycle pulse at end of operation
- vf_out  out  1  collision result; valid from done, held until next accepted start
- mem_read  out  1  memory read request
- mem_addr  out  12  read address, (i_addr + row) mod 4096
- mem_gnt  in  1  memory grant; request accepted in a cycle with mem_read=1 and mem_gnt=1
- mem_data  in  8  read data, valid the cycle after grant
- draw  out  1  one-cycle row draw strobe to display unit
- draw_x  out  6  latched x_in
- draw_y  out  5  y+row (mod 32 when CLIP=0)
- row_index  out  4  current row, 0..N-1
- sprite_data  out  8  latched sprite byte for current row
- collision  in  1  display unit collision, combinational, valid in the draw cycle

## Operation
- States: IDLE, FETCH, WAIT, DRAW, DONE.
- IDLE: on start=1, latch x_in, y_in, n_in, i_addr. Clear row counter and VF accumulator. Go to FETCH, or to DONE if n_in=0, or if CLIP=1 and y_in+0 ≥ 32 (not possible; y<32).
- FETCH: mem_read=1, mem_addr=(I+row)[11:0]. Hold until mem_gnt=1, then go to WAIT.
- WAIT: latch mem_data into the sprite register, then go to DRAW.
- DRAW: draw=1 for exactly one cycle. In that cycle:
  - draw_x = latched X, draw_y = row Y, row_index = row, sprite_data = latched byte.
  - vf_acc |= collision.
  - Increment row. If row+1 = N, or (CLIP=1 and y+row+1 ≥ 32), go to DONE; else go to FETCH.
- DONE: done=1, vf_out=vf_acc, then go to IDLE.
- Row Y arithmetic: 6-bit sum y+row. For CLIP=0, draw_y = sum[4:0]. For CLIP=1, a sum ≥ 32 terminates the operation.
- Address arithmetic: 12-bit wrap, so 0xFFF+1 = 0x000.
- start while busy: ignored; latched operands are unchanged.
- Outputs outside their active states: mem_read=0 and draw=0. draw_x, draw_y, row_index and sprite_data hold their last values.
- reset=0 at any clock edge, including mid-operation: state IDLE, and all outputs 0 (vf_out, busy, done, draw, mem_read, mem_addr, draw_x, draw_y, row_index, sprite_data). No further draw or read is issued.

## Timing
- Accepted start in cycle t. Then FETCH row 0 in t+1.
- With mem_gnt held high, each row takes 3 cycles (FETCH, WAIT, DRAW). DRAW of row r falls in cycle t+3+3r, and done falls in cycle t+3R+1, where R = rows drawn.
- N=0: done in cycle t+1, vf_out=0, no mem_read, no draw.
- Each cycle FETCH waits for grant adds one cycle of latency. mem_addr is stable while mem_read=1.
- busy=1 from t+1 through the done cycle inclusive. A new start is accepted in the cycle after done.
- draw never coincides with mem_read.

## Test plan
- Basic draw: start with X=10, Y=4, N=1, I=0x200, mem[0x200]=0xF0, grant held, collision=0.
  - Required: mem_read at t+1 with addr 0x200, draw at t+3 with sprite_data=0xF0, x=10, y=4, row 0.
  - Required: done at t+4, vf_out=0.
- Font sprite with collision: N=5, I=0x050, bytes F0 90 90 90 F0, collision=1 only on row 2.
  - Required: 5 draws at t+3, 6, 9, 12, 15 with rows 0..4 and y=Y..Y+4.
  - Required: done at t+16, vf_out=1.
- Clip vs wrap: Y=30, N=5.
  - CLIP=1: only rows 0 and 1 drawn (y=30, 31), done at t+7.
  - CLIP=0: 5 draws with y=30, 31, 0, 1, 2.
- Grant stall and address wrap: I=0xFFE, N=3, mem_gnt low for 2 cycles on each FETCH.
  - Required: addresses 0xFFE, 0xFFF, 0x000, each held stable during its stall.
  - Required: done at t+16.
- N=0 and start-while-busy:
  - N=0: done at t+1, vf_out=0, no draw.
  - start pulsed during busy with different operands: ignored, and the original rows complete unchanged.
- Reset mid-operation: reset=0 during DRAW of row 2 of 5.
  - Required: the next cycle is IDLE with all outputs 0 and no further draw.
  - Required: a subsequent start runs normally.

Source files
------------

// File: rtl/chip8_draw_seq.sv
// chip8_draw_seq: sequences a CHIP-8 DXYN sprite draw. Fetches N sprite bytes
// starting at I through a request/grant memory port, issues one draw strobe per
// row to the display unit, ORs the per-row collision flags into VF and reports
// completion with a one-cycle done pulse.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_ni       synchronous active-low reset
//   start_i        one-cycle DXYN request, sampled only when idle
//   x_i/y_i/n_i    sprite X (0..63), Y (0..31), height (0..15)
//   i_addr_i       sprite base address (I register)
//   busy_o         operation in progress (cycle after start through done)
//   done_o         one-cycle completion pulse
//   vf_out_o       collision result, valid from done until next start
//   mem_read_o     memory read request, held until mem_gnt_i
//   mem_addr_o     read address, (I + row) mod 4096
//   mem_gnt_i      memory grant
//   mem_data_i     read data, valid the cycle after grant
//   draw_o         one-cycle row draw strobe
//   draw_x_o       sprite X for the row
//   draw_y_o       row Y, y + row (mod 32 when wrapping)
//   row_index_o    current row
//   sprite_data_o  sprite byte for the row
//   collision_i    display collision flag, combinational in the draw cycle
module chip8_draw_seq #(
  parameter bit CLIP = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        start_i,
  input  logic [5:0]  x_i,
  input  logic [4:0]  y_i,
  input  logic [3:0]  n_i,
  input  logic [11:0] i_addr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        vf_out_o,
  output logic        mem_read_o,
  output logic [11:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_data_i,
  output logic        draw_o,
  output logic [5:0]  draw_x_o,
  output logic [4:0]  draw_y_o,
  output logic [3:0]  row_index_o,
  output logic [7:0]  sprite_data_o,
  input  logic        collision_i
);

  localparam int unsigned XW = 6;
  localparam int unsigned YW = 5;
  localparam int unsigned NW = 4;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DRAW,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [NW-1:0] n_q, n_d;
  logic [AW-1:0] i_q, i_d;
  logic [NW-1:0] row_q, row_d;
  logic          vf_acc_q, vf_acc_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          vf_q, vf_d;
  logic          mem_read_q, mem_read_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          draw_q, draw_d;
  logic [XW-1:0] draw_x_q, draw_x_d;
  logic [YW-1:0] draw_y_q, draw_y_d;
  logic [NW-1:0] row_idx_q, row_idx_d;
  logic [DW-1:0] sprite_q, sprite_d;

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      n_q        <= '0;
      i_q        <= '0;
      row_q      <= '0;
      vf_acc_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vf_q       <= 1'b0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
      draw_q     <= 1'b0;
      draw_x_q   <= '0;
      draw_y_q   <= '0;
      row_idx_q  <= '0;
      sprite_q   <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      n_q        <= n_d;
      i_q        <= i_d;
      row_q      <= row_d;
      vf_acc_q   <= vf_acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      vf_q       <= vf_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      draw_q     <= draw_d;
      draw_x_q   <= draw_x_d;
      draw_y_q   <= draw_y_d;
      row_idx_q  <= row_idx_d;
      sprite_q   <= sprite_d;
    end
  end

  // Next state, operand latching, and output values derived from the next state
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    n_d        = n_q;
    i_d        = i_q;
    row_d      = row_q;
    vf_acc_d   = vf_acc_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    vf_d       = vf_q;
    mem_read_d = 1'b0;
    mem_addr_d = mem_addr_q;
    draw_d     = 1'b0;
    draw_x_d   = draw_x_q;
    draw_y_d   = draw_y_q;
    row_idx_d  = row_idx_q;
    sprite_d   = sprite_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          x_d      = x_i;
          y_d      = y_i;
          n_d      = n_i;
          i_d      = i_addr_i;
          row_d    = '0;
          vf_acc_d = 1'b0;
          state_d  = (n_i == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_DRAW;
      end
      S_DRAW: begin
        vf_acc_d = vf_acc_q | collision_i;
        row_d    = row_q + NW'(1);
        // Last row reached, or the next row would fall off the bottom edge
        if ((row_q + NW'(1)) == n_q ||
            (CLIP && (({1'b0, y_q} + {2'b00, row_q} + 6'd1) >= 6'd32))) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are computed from the state being entered
    busy_d     = (state_d != S_IDLE);
    mem_read_d = (state_d == S_FETCH);
    done_d     = (state_d == S_DONE);
    draw_d     = (state_d == S_DRAW);

    if (state_d == S_FETCH) mem_addr_d = i_d + AW'(row_d);
    if (state_d == S_DONE)  vf_d = vf_acc_d;
    // DRAW is only entered from WAIT, where mem_data_i holds the granted byte
    if (state_d == S_DRAW) begin
      draw_x_d  = x_q;
      draw_y_d  = y_q + YW'(row_q);
      row_idx_d = row_q;
      sprite_d  = mem_data_i;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign vf_out_o      = vf_q;
  assign mem_read_o    = mem_read_q;
  assign mem_addr_o    = mem_addr_q;
  assign draw_o        = draw_q;
  assign draw_x_o      = draw_x_q;
  assign draw_y_o      = draw_y_q;
  assign row_index_o   = row_idx_q;
  assign sprite_data_o = sprite_q;

endmodule

// File: tb/tb_chip8_draw_seq.sv
// Testbench for chip8_draw_seq: one instance clips (CLIP=1), one wraps (CLIP=0);
// sel chooses which one is driven and observed.
module tb_chip8_draw_seq;

  typedef struct {
    int         cyc;
    logic [5:0] x;
    logic [4:0] y;
    logic [3:0] row;
    logic [7:0] data;
  } draw_t;

  typedef struct {
    int   cyc;
    logic vf;
  } done_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [5:0]  x_in = '0;
  logic [4:0]  y_in = '0;
  logic [3:0]  n_in = '0;
  logic [11:0] i_in = '0;
  logic        mem_gnt = 1'b1;
  logic [7:0]  mem_data = '0;
  logic        collision = 1'b0;

  logic busy0, busy1, done0, done1, vf0, vf1, rd0, rd1, drw0, drw1;
  logic [11:0] addr0, addr1;
  logic [5:0]  dx0, dx1;
  logic [4:0]  dy0, dy1;
  logic [3:0]  ri0, ri1;
  logic [7:0]  sd0, sd1;

  logic start0, start1;
  assign start0 = start & ~sel;
  assign start1 = start & sel;

  chip8_draw_seq #(.CLIP(1'b1)) u_clip (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start0),
    .x_i(x_in), .y_i(y_in), .n_i(n_in), .i_addr_i(i_in),
    .busy_o(busy0), .done_o(done0), .vf_out_o(vf0),
    .mem_read_o(rd0), .mem_addr_o(addr0), .mem_gnt_i(mem_gnt), .mem_data_i(mem_data),
    .draw_o(drw0), .draw_x_o(dx0), .draw_y_o(dy0), .row_index_o(ri0),
    .sprite_data_o(sd0), .collision_i(collision)
  );

  chip8_draw_seq #(.CLIP(1'b0)) u_wrap (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start1),
    .x_i(x_in), .y_i(y_in), .n_i(n_in), .i_addr_i(i_in),
    .busy_o(busy1), .done_o(done1), .vf_out_o(vf1),
    .mem_read_o(rd1), .mem_addr_o(addr1), .mem_gnt_i(mem_gnt), .mem_data_i(mem_data),
    .draw_o(drw1), .draw_x_o(dx1), .draw_y_o(dy1), .row_index_o(ri1),
    .sprite_data_o(sd1), .collision_i(collision)
  );

  logic        busy, done, vf_out, mem_read, draw;
  logic [11:0] mem_addr;
  logic [5:0]  draw_x;
  logic [4:0]  draw_y;
  logic [3:0]  row_index;
  logic [7:0]  sprite_data;
  assign busy        = sel ? busy1 : busy0;
  assign done        = sel ? done1 : done0;
  assign vf_out      = sel ? vf1 : vf0;
  assign mem_read    = sel ? rd1 : rd0;
  assign mem_addr    = sel ? addr1 : addr0;
  assign draw        = sel ? drw1 : drw0;
  assign draw_x      = sel ? dx1 : dx0;
  assign draw_y      = sel ? dy1 : dy0;
  assign row_index   = sel ? ri1 : ri0;
  assign sprite_data = sel ? sd1 : sd0;

  logic [7:0]  mem [4096];
  logic [15:0] coll_mask = '0;
  bit          stall_mode = 1'b0;
  int          stall_cnt = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: data appears the cycle after an accepted request
  always @(posedge clk) begin
    if (mem_read && mem_gnt) mem_data <= mem[mem_addr];
  end

  draw_t exp_draw[$];
  logic [11:0] exp_addr[$];
  done_t exp_done[$];

  int n_chk = 0;
  int n_fail = 0;
  int n_draws = 0;
  int last_done_cyc = -1;
  logic last_vf = 1'b0;
  int t_start = 0;

  draw_t ed;
  done_t edn;
  logic [11:0] ea;
  logic        prev_read = 1'b0;
  logic [11:0] prev_addr = '0;

  // Grant/collision driver and scoreboard checker, sampled on the falling edge
  always @(negedge clk) begin
    if (stall_mode) begin
      if (mem_read) begin
        if (stall_cnt < 2) begin
          mem_gnt = 1'b0;
          stall_cnt = stall_cnt + 1;
        end else begin
          mem_gnt = 1'b1;
          stall_cnt = 0;
        end
      end else begin
        mem_gnt = 1'b0;
      end
    end else begin
      mem_gnt = 1'b1;
    end
    collision = draw & coll_mask[row_index];

    if (reset_n) begin
      if (draw) begin
        n_draws = n_draws + 1;
        n_chk = n_chk + 1;
        if (mem_read !== 1'b0) begin
          n_fail = n_fail + 1;
          $display("FAIL draw_read_overlap: cyc=%0d mem_read=%b required 0", cyc, mem_read);
        end
        n_chk = n_chk + 1;
        if (exp_draw.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL unexpected_draw: cyc=%0d row=%0d y=%0d", cyc, row_index, draw_y);
        end else begin
          ed = exp_draw.pop_front();
          if (cyc !== ed.cyc || draw_x !== ed.x || draw_y !== ed.y ||
              row_index !== ed.row || sprite_data !== ed.data) begin
            n_fail = n_fail + 1;
            $display("FAIL draw_row: got cyc=%0d x=%0d y=%0d row=%0d data=%h, required cyc=%0d x=%0d y=%0d row=%0d data=%h",
                     cyc, draw_x, draw_y, row_index, sprite_data, ed.cyc, ed.x, ed.y, ed.row, ed.data);
          end
        end
      end
      if (mem_read) begin
        if (prev_read) begin
          n_chk = n_chk + 1;
          if (mem_addr !== prev_addr) begin
            n_fail = n_fail + 1;
            $display("FAIL addr_stable: cyc=%0d addr=%h required %h", cyc, mem_addr, prev_addr);
          end
        end
        if (mem_gnt) begin
          n_chk = n_chk + 1;
          if (exp_addr.size() == 0) begin
            n_fail = n_fail + 1;
            $display("FAIL unexpected_read: cyc=%0d addr=%h", cyc, mem_addr);
          end else begin
            ea = exp_addr.pop_front();
            if (mem_addr !== ea) begin
              n_fail = n_fail + 1;
              $display("FAIL read_addr: got %h required %h at cyc=%0d", mem_addr, ea, cyc);
            end
          end
        end
      end
      if (done) begin
        last_done_cyc = cyc;
        last_vf = vf_out;
        n_chk = n_chk + 1;
        if (exp_done.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL unexpected_done: cyc=%0d", cyc);
        end else begin
          edn = exp_done.pop_front();
          if (cyc !== edn.cyc || vf_out !== edn.vf || busy !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL done: got cyc=%0d vf=%b busy=%b, required cyc=%0d vf=%b busy=1",
                     cyc, vf_out, busy, edn.cyc, edn.vf);
          end
        end
      end
    end
    prev_read = mem_read;
    prev_addr = mem_addr;
  end

  // Reference model: expected reads, draws and done for an operation started in cycle t
  task automatic push_expect(input int t, input int x, input int y, input int n, input int i);
    int    s;
    int    rows;
    logic  vf;
    draw_t e;
    done_t d;
    s = stall_mode ? 2 : 0;
    rows = 0;
    vf = 1'b0;
    for (int r = 0; r < n; r++) begin
      if (!sel && (y + r) >= 32) break;
      e.cyc  = t + 3 + s + (3 + s) * r;
      e.x    = 6'(x);
      e.y    = 5'((y + r) % 32);
      e.row  = 4'(r);
      e.data = mem[(i + r) % 4096];
      exp_draw.push_back(e);
      exp_addr.push_back(12'((i + r) % 4096));
      vf = vf | coll_mask[r];
      rows = rows + 1;
    end
    d.cyc = t + (3 + s) * rows + 1;
    d.vf  = vf;
    exp_done.push_back(d);
  endtask

  task automatic do_start(input int x, input int y, input int n, input int i);
    @(negedge clk);
    t_start = cyc;
    push_expect(cyc, x, y, n, i);
    start = 1'b1;
    x_in = 6'(x);
    y_in = 5'(y);
    n_in = 4'(n);
    i_in = 12'(i);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit timeout);
    int k;
    k = 0;
    while (exp_done.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    timeout = (exp_done.size() != 0);
  endtask

  task automatic flush_sb();
    exp_draw.delete();
    exp_addr.delete();
    exp_done.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk = n_chk + 1;
    if ({busy0, done0, vf0, rd0, addr0, drw0, dx0, dy0, ri0, sd0,
         busy1, done1, vf1, rd1, addr1, drw1, dx1, dy1, ri1, sd1} !== 80'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_outputs: busy=%b done=%b vf=%b rd=%b addr=%h draw=%b, required all 0",
               busy0, done0, vf0, rd0, addr0, drw0);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic(input string name);
    bit to;
    int d0;
    mem[12'h200] = 8'hF0;
    coll_mask = '0;
    d0 = n_draws;
    do_start(10, 4, 1, 12'h200);
    n_chk = n_chk + 1;
    if (busy !== 1'b1 || mem_read !== 1'b1 || mem_addr !== 12'h200) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_first_fetch: busy=%b rd=%b addr=%h, required 1 1 200", name, busy, mem_read, mem_addr);
    end
    wait_idle(20, to);
    n_chk = n_chk + 1;
    if (to || exp_draw.size() != 0 || exp_addr.size() != 0 || last_done_cyc != t_start + 4 ||
        last_vf !== 1'b0 || n_draws - d0 != 1) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_complete: done_cyc=%0d vf=%b draws=%0d, required %0d 0 1",
               name, last_done_cyc, last_vf, n_draws - d0, t_start + 4);
    end
    flush_sb();
    @(negedge clk);
    n_chk = n_chk + 1;
    if (busy !== 1'b0 || sprite_data !== 8'hF0 || draw_x !== 6'd10 || draw_y !== 5'd4) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_hold: busy=%b data=%h x=%0d y=%0d, required 0 f0 10 4",
               name, busy, sprite_data, draw_x, draw_y);
    end
  endtask

  task automatic test_font_collision();
    bit to;
    int d0;
    mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
    mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
    coll_mask = 16'h0004;
    d0 = n_draws;
    do_start(20, 8, 5, 12'h050);
    wait_idle(40, to);
    n_chk = n_chk + 1;
    if (to || exp_draw.size() != 0 || last_done_cyc != t_start + 16 || last_vf !== 1'b1 ||
        n_draws - d0 != 5) begin
      n_fail = n_fail + 1;
      $display("FAIL font_complete: done_cyc=%0d vf=%b draws=%0d, required %0d 1 5",
               last_done_cyc, last_vf, n_draws - d0, t_start + 16);
    end
    flush_sb();
    repeat (3) @(negedge clk);
    n_chk = n_chk + 1;
    if (vf_out !== 1'b1 || busy !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL font_vf_hold: vf=%b busy=%b, required 1 0", vf_out, busy);
    end
    coll_mask = '0;
  endtask

  task automatic test_clip_wrap();
    bit to;
    int d0;
    for (int k = 0; k < 5; k++) mem[12'h300 + k] = 8'(8'hA1 + k);
    sel = 1'b0;
    d0 = n_draws;
    do_start(0, 30, 5, 12'h300);
    wait_idle(40, to);
    n_chk = n_chk + 1;
    if (to || exp_draw.size() != 0 || last_done_cyc != t_start + 7 || n_draws - d0 != 2) begin
      n_fail = n_fail + 1;
      $display("FAIL clip_complete: done_cyc=%0d draws=%0d, required %0d 2",
               last_done_cyc, n_draws - d0, t_start + 7);
    end
    flush_sb();
    @(negedge clk);
    sel = 1'b1;
    d0 = n_draws;
    do_start(0, 30, 5, 12'h300);
    wait_idle(40, to);
    n_chk = n_chk + 1;
    if (to || exp_draw.size() != 0 || last_done_cyc != t_start + 16 || n_draws - d0 != 5 ||
        draw_y !== 5'd2) begin
      n_fail = n_fail + 1;
      $display("FAIL wrap_complete: done_cyc=%0d draws=%0d last_y=%0d, required %0d 5 2",
               last_done_cyc, n_draws - d0, draw_y, t_start + 16);
    end
    flush_sb();
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_stall_wrap();
    bit to;
    mem[12'hFFE] = 8'h11; mem[12'hFFF] = 8'h22; mem[12'h000] = 8'h33;
    coll_mask = 16'h0001;
    stall_cnt = 0;
    stall_mode = 1'b1;
    do_start(63, 0, 3, 12'hFFE);
    wait_idle(60, to);
    n_chk = n_chk + 1;
    if (to || exp_draw.size() != 0 || exp_addr.size() != 0 || last_done_cyc != t_start + 16 ||
        last_vf !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL stall_complete: done_cyc=%0d vf=%b, required %0d 1", last_done_cyc, last_vf, t_start + 16);
    end
    flush_sb();
    stall_mode = 1'b0;
    coll_mask = '0;
    @(negedge clk);
  endtask

  task automatic test_n_zero();
    bit to;
    int d0;
    d0 = n_draws;
    do_start(1, 2, 0, 12'h123);
    wait_idle(10, to);
    n_chk = n_chk + 1;
    if (to || last_done_cyc != t_start + 1 || last_vf !== 1'b0 || n_draws - d0 != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL n0_complete: done_cyc=%0d vf=%b draws=%0d, required %0d 0 0",
               last_done_cyc, last_vf, n_draws - d0, t_start + 1);
    end
    flush_sb();
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    bit to;
    int d0;
    for (int k = 0; k < 3; k++) mem[12'h400 + k] = 8'(8'h5A ^ k);
    d0 = n_draws;
    do_start(7, 9, 3, 12'h400);
    @(negedge clk);
    start = 1'b1;
    x_in = 6'd50; y_in = 5'd1; n_in = 4'd9; i_in = 12'h800;
    @(negedge clk);
    start = 1'b0;
    wait_idle(40, to);
    n_chk = n_chk + 1;
    if (to || exp_draw.size() != 0 || last_done_cyc != t_start + 10 || n_draws - d0 != 3) begin
      n_fail = n_fail + 1;
      $display("FAIL busy_start: done_cyc=%0d draws=%0d, required %0d 3",
               last_done_cyc, n_draws - d0, t_start + 10);
    end
    flush_sb();
    repeat (4) @(negedge clk);
    n_chk = n_chk + 1;
    if (busy !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL busy_start_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    int d0;
    for (int j = 0; j < 5; j++) mem[12'h500 + j] = 8'(8'h80 >> j);
    coll_mask = 16'h0001;
    do_start(3, 3, 5, 12'h500);
    k = 0;
    while (!(draw && row_index == 4'd2) && k < 30) begin
      @(negedge clk);
      k++;
    end
    n_chk = n_chk + 1;
    if (k >= 30) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_mid_reach: row 2 draw not seen, cycles=%0d", k);
    end
    reset_n = 1'b0;
    @(negedge clk);
    flush_sb();
    n_chk = n_chk + 1;
    if ({busy0, done0, vf0, rd0, addr0, drw0, dx0, dy0, ri0, sd0} !== 40'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_mid_outputs: busy=%b done=%b vf=%b rd=%b addr=%h draw=%b x=%0d y=%0d row=%0d data=%h, required all 0",
               busy0, done0, vf0, rd0, addr0, drw0, dx0, dy0, ri0, sd0);
    end
    reset_n = 1'b1;
    coll_mask = '0;
    d0 = n_draws;
    repeat (12) @(negedge clk);
    n_chk = n_chk + 1;
    if (n_draws != d0 || busy !== 1'b0 || mem_read !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_mid_quiet: draws=%0d busy=%b rd=%b, required 0 0 0", n_draws - d0, busy, mem_read);
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    test_reset();
    test_basic("basic");
    test_font_collision();
    test_clip_wrap();
    test_stall_wrap();
    test_n_zero();
    test_start_while_busy();
    test_reset_mid();
    test_basic("after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
